// File: rtl/loop_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : loop_bank_sequencer
// Purpose  : Multi-bank looper sequencer. Owns the per-bank record/play
//            state, the master loop length and loop position, and serialises
//            one memory access per active bank for every audio frame.
// Ports    : clk, rst (async, active-high)
//            btn_press / clear / bank_sel : bank control pulses
//            frame_tick                   : start of a sample frame
//            mem_req/mem_we/mem_addr/mem_ack : memory request handshake
//            recording/playing/active     : per-bank status vectors
//            loop_len                     : master loop length (0 = undefined)
//            frame_done                   : frame serviced pulse
//            overrun                      : sticky dropped-frame flag
// Options  : LOOP_OVERDUB_EN adds the OVERDUB bank state
//            (read then write of the same address each frame).
// Revision : 1.0 - initial release
// ============================================================================
module loop_bank_sequencer #(
    parameter int BANK_W = 4,
    parameter int ADDR_W = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_press,
    input  logic                     clear,
    input  logic [BANK_W-1:0]        bank_sel,
    input  logic                     frame_tick,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [BANK_W+ADDR_W-1:0] mem_addr,
    input  logic                     mem_ack,
    output logic [(2**BANK_W)-1:0]   recording,
    output logic [(2**BANK_W)-1:0]   playing,
    output logic [(2**BANK_W)-1:0]   active,
    output logic [ADDR_W:0]          loop_len,
    output logic                     frame_done,
    output logic                     overrun
);

    localparam int NB = 2**BANK_W;

    localparam logic [BANK_W-1:0] c_last_bank = {BANK_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_pos_max   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   c_len_full  = {1'b1, {ADDR_W{1'b0}}};

    // Per-bank states
    localparam logic [2:0] c_bk_empty   = 3'd0;
    localparam logic [2:0] c_bk_record  = 3'd1;
    localparam logic [2:0] c_bk_play    = 3'd2;
    localparam logic [2:0] c_bk_mute    = 3'd3;
`ifdef LOOP_OVERDUB_EN
    localparam logic [2:0] c_bk_overdub = 3'd4;
`endif

    // Scheduler states
    localparam logic [1:0] c_sch_idle = 2'd0;
    localparam logic [1:0] c_sch_scan = 2'd1;
    localparam logic [1:0] c_sch_req  = 2'd2;

    logic [2:0]              r_bank [NB];
    logic [2:0]              w_bank_nx [NB];
    logic [ADDR_W-1:0]       r_pos;
    logic [ADDR_W-1:0]       w_pos_nx;
    logic [ADDR_W:0]         r_len;
    logic [ADDR_W:0]         w_len_nx;
    logic                    r_wrote;
    logic                    w_wrote_nx;

    logic [1:0]              r_sch;
    logic [BANK_W-1:0]       r_idx;
    logic [ADDR_W-1:0]       r_off;
    logic                    r_req;
    logic                    r_we;
    logic [BANK_W+ADDR_W-1:0] r_addr;
    logic                    r_done;
    logic                    r_ovr;
`ifdef LOOP_OVERDUB_EN
    logic                    r_od_pend;   // overdub read done, write still owed
`endif

    logic [2:0]              w_cur;
    logic                    w_svc;
    logic                    w_last_acc;
    logic                    w_frame_end;
    logic                    w_wrote_now;
    logic                    w_any_rec;
    logic                    w_any_left;

    // ------------------------------------------------------------------
    // Scheduler decode
    // ------------------------------------------------------------------
    assign w_cur = r_bank[r_idx];

`ifdef LOOP_OVERDUB_EN
    assign w_svc      = (w_cur == c_bk_record) || (w_cur == c_bk_play) ||
                        (w_cur == c_bk_overdub);
    assign w_last_acc = !r_od_pend;
`else
    assign w_svc      = (w_cur == c_bk_record) || (w_cur == c_bk_play);
    assign w_last_acc = 1'b1;
`endif

    // The cycle on which the last bank of the frame is finished.
    assign w_frame_end = (r_idx == c_last_bank) &&
                         (((r_sch == c_sch_scan) && !w_svc) ||
                          ((r_sch == c_sch_req) && mem_ack && w_last_acc));

    assign w_wrote_now = (r_sch == c_sch_req) && mem_ack && r_we &&
                         (w_cur == c_bk_record);

    always_comb begin
        w_any_rec = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (r_bank[i] == c_bk_record) begin
                w_any_rec = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank / position next state. Frame-end effects are applied first and
    // the button/clear action is layered on top, so a user action in the
    // same cycle wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_bank_nx  = r_bank;
        w_pos_nx   = r_pos;
        w_len_nx   = r_len;
        w_wrote_nx = r_wrote | w_wrote_now;
        w_any_left = 1'b0;

        if (w_frame_end) begin
            if (r_len == '0) begin
                // Undefined length: pos only runs while the first loop records.
                if (w_any_rec) begin
                    if (r_pos == c_pos_max) begin
                        w_len_nx   = c_len_full;
                        w_pos_nx   = '0;
                        w_wrote_nx = 1'b0;
                        for (int i = 0; i < NB; i++) begin
                            if (r_bank[i] == c_bk_record) begin
                                w_bank_nx[i] = c_bk_play;
                            end
                        end
                    end else begin
                        w_pos_nx = r_pos + 1'b1;
                    end
                end
            end else if ({1'b0, r_pos} == (r_len - 1'b1)) begin
                w_pos_nx = '0;
                // Wrap after a written frame closes an overlay recording.
                if (w_wrote_nx) begin
                    w_wrote_nx = 1'b0;
                    for (int i = 0; i < NB; i++) begin
                        if (r_bank[i] == c_bk_record) begin
                            w_bank_nx[i] = c_bk_play;
                        end
                    end
                end
            end else begin
                w_pos_nx = r_pos + 1'b1;
            end
        end

        if (clear) begin
            if ((r_bank[bank_sel] == c_bk_record) && (r_len == '0)) begin
                w_pos_nx = '0;
            end
            w_bank_nx[bank_sel] = c_bk_empty;
            for (int i = 0; i < NB; i++) begin
                if (w_bank_nx[i] != c_bk_empty) begin
                    w_any_left = 1'b1;
                end
            end
            if (!w_any_left) begin
                w_len_nx = '0;
                w_pos_nx = '0;
            end
        end else if (btn_press) begin
            case (w_bank_nx[bank_sel])
                c_bk_empty: begin
                    // Only one recorder: any current one is pushed to PLAY,
                    // which also closes a first recording.
                    for (int i = 0; i < NB; i++) begin
                        if (w_bank_nx[i] == c_bk_record) begin
                            w_bank_nx[i] = c_bk_play;
                            if (w_len_nx == '0) begin
                                w_len_nx = {1'b0, w_pos_nx};
                                w_pos_nx = '0;
                            end
                        end
                    end
                    if (w_len_nx == '0) begin
                        w_pos_nx = '0;
                    end
                    w_bank_nx[bank_sel] = c_bk_record;
                    w_wrote_nx          = 1'b0;
                end
                c_bk_record: begin
                    w_bank_nx[bank_sel] = c_bk_play;
                    w_wrote_nx          = 1'b0;
                    if (w_len_nx == '0) begin
                        w_len_nx = {1'b0, w_pos_nx};
                        w_pos_nx = '0;
                    end
                end
`ifdef LOOP_OVERDUB_EN
                c_bk_play:    w_bank_nx[bank_sel] = c_bk_overdub;
                c_bk_overdub: w_bank_nx[bank_sel] = c_bk_mute;
`else
                c_bk_play:    w_bank_nx[bank_sel] = c_bk_mute;
`endif
                c_bk_mute:    w_bank_nx[bank_sel] = c_bk_play;
                default:      w_bank_nx[bank_sel] = c_bk_empty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                r_bank[i] <= c_bk_empty;
            end
            r_pos   <= '0;
            r_len   <= '0;
            r_wrote <= 1'b0;
        end else begin
            r_bank  <= w_bank_nx;
            r_pos   <= w_pos_nx;
            r_len   <= w_len_nx;
            r_wrote <= w_wrote_nx;
        end
    end

    // ------------------------------------------------------------------
    // Memory request scheduler
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sch     <= c_sch_idle;
            r_idx     <= '0;
            r_off     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef LOOP_OVERDUB_EN
            r_od_pend <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (frame_tick && (r_sch != c_sch_idle)) begin
                r_ovr <= 1'b1;
            end
            case (r_sch)
                c_sch_idle: begin
                    if (frame_tick) begin
                        r_off <= r_pos;
                        r_idx <= '0;
                        r_sch <= c_sch_scan;
                    end
                end
                c_sch_scan: begin
                    if (w_svc) begin
                        r_req  <= 1'b1;
                        r_we   <= (w_cur == c_bk_record);
                        r_addr <= {r_idx, r_off};
                        r_sch  <= c_sch_req;
`ifdef LOOP_OVERDUB_EN
                        r_od_pend <= (w_cur == c_bk_overdub);
`endif
                    end else if (r_idx == c_last_bank) begin
                        r_done <= 1'b1;
                        r_sch  <= c_sch_idle;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_sch_req: begin
                    if (mem_ack) begin
`ifdef LOOP_OVERDUB_EN
                        if (r_od_pend) begin
                            // Second half of an overdub: same address, write.
                            r_we      <= 1'b1;
                            r_od_pend <= 1'b0;
                        end else begin
`else
                        begin
`endif
                            r_req <= 1'b0;
                            if (r_idx == c_last_bank) begin
                                r_done <= 1'b1;
                                r_sch  <= c_sch_idle;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                                r_sch <= c_sch_scan;
                            end
                        end
                    end
                end
                default: r_sch <= c_sch_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_status
`ifdef LOOP_OVERDUB_EN
            assign recording[gi] = (r_bank[gi] == c_bk_record) ||
                                   (r_bank[gi] == c_bk_overdub);
            assign playing[gi]   = (r_bank[gi] == c_bk_play) ||
                                   (r_bank[gi] == c_bk_overdub);
`else
            assign recording[gi] = (r_bank[gi] == c_bk_record);
            assign playing[gi]   = (r_bank[gi] == c_bk_play);
`endif
            assign active[gi]    = (r_bank[gi] != c_bk_empty);
        end
    endgenerate

    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign loop_len   = r_len;
    assign frame_done = r_done;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_loop_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_bank_sequencer
// Purpose  : Self-checking bench for loop_bank_sequencer (BANK_W=3, ADDR_W=7).
//            Press/clear vector table plus frame-level scenarios; expected
//            memory accesses are queued when a frame is started and compared
//            when the memory model acknowledges them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_bank_sequencer;

    localparam int BW    = 3;
    localparam int AW    = 7;
    localparam int NB    = 8;
    localparam int BOUND = 400;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_press = 1'b0;
    logic          clear = 1'b0;
    logic [BW-1:0] bank_sel = '0;
    logic          frame_tick = 1'b0;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic [BW+AW-1:0] mem_addr;
    logic [NB-1:0] recording;
    logic [NB-1:0] playing;
    logic [NB-1:0] active;
    logic [AW:0]   loop_len;
    logic          frame_done;
    logic          overrun;

    int checks   = 0;
    int failures = 0;
    int ack_dly  = 0;

    typedef struct {
        logic             we;
        logic [BW+AW-1:0] addr;
    } acc_t;
    acc_t sb[$];

    typedef struct {
        logic          prs;
        logic          clr;
        int            bank;
        logic [NB-1:0] rec;
        logic [NB-1:0] play;
        logic [NB-1:0] act;
    } vec_t;
    vec_t tbl[$];

    // Bench-side expectation of which banks read / write each frame.
    logic [NB-1:0] rd_mask = '0;
    logic [NB-1:0] wr_mask = '0;
    int            exp_pos = 0;
    int            exp_len = 0;

    loop_bank_sequencer #(.BANK_W(BW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_press  (btn_press),
        .clear      (clear),
        .bank_sel   (bank_sel),
        .frame_tick (frame_tick),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .recording  (recording),
        .playing    (playing),
        .active     (active),
        .loop_len   (loop_len),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic act_on(input int b, input logic prs, input logic clr);
        bank_sel  = BW'(b);
        btn_press = prs;
        clear     = clr;
        step();
        btn_press = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic push_frame();
        acc_t e;
        for (int b = 0; b < NB; b++) begin
            if (rd_mask[b]) begin
                e.we   = 1'b0;
                e.addr = (10'(b) << AW) | 10'(exp_pos);
                sb.push_back(e);
            end
            if (wr_mask[b]) begin
                e.we   = 1'b1;
                e.addr = (10'(b) << AW) | 10'(exp_pos);
                sb.push_back(e);
            end
        end
        if (exp_len != 0) exp_pos = (exp_pos + 1) % exp_len;
        else if (wr_mask != '0) exp_pos = exp_pos + 1;
    endtask

    // Starts a frame, optionally fires a second tick while a request is
    // outstanding, and returns the cycles from tick to frame_done.
    task automatic run_frame(input bit inject, output int n);
        bit injected;
        injected = 1'b0;
        push_frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n = 1;
        while (!frame_done && n < BOUND) begin
            if (inject && !injected && mem_req) begin
                frame_tick = 1'b1;
                injected   = 1'b1;
            end
            step();
            frame_tick = 1'b0;
            n++;
        end
        if (n >= BOUND) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout cycles=%0d", n);
        end
        check("frame_all_acc_seen", sb.size(), 0);
        sb.delete();
    endtask

    // Memory model: acknowledges after ack_dly waiting cycles, checks the
    // request is stable while waiting and scores each accepted access.
    initial begin
        int   wait_cnt;
        logic held_we;
        logic [BW+AW-1:0] held_addr;
        acc_t e;
        mem_ack  = 1'b0;
        wait_cnt = 0;
        held_we  = 1'b0;
        held_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (mem_req && !rst) begin
                if (wait_cnt == 0) begin
                    held_we   = mem_we;
                    held_addr = mem_addr;
                end else begin
                    check("req_stable", {mem_we, mem_addr}, {held_we, held_addr});
                end
                if (wait_cnt >= ack_dly) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_access actual=%0h/%0h required=none", mem_we, mem_addr);
                    end else begin
                        e = sb.pop_front();
                        check("acc_we", mem_we, e.we);
                        check("acc_addr", mem_addr, e.addr);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        int n;

        // Press/clear vectors (no frames run, so pos stays 0).
        tbl.push_back('{1'b1, 1'b0, 2, 8'h04, 8'h00, 8'h04});
        tbl.push_back('{1'b1, 1'b0, 5, 8'h20, 8'h04, 8'h24}); // displaces bank 2
        tbl.push_back('{1'b1, 1'b0, 5, 8'h00, 8'h24, 8'h24});
`ifdef LOOP_OVERDUB_EN
        tbl.push_back('{1'b1, 1'b0, 2, 8'h04, 8'h24, 8'h24}); // overdub
`endif
        tbl.push_back('{1'b1, 1'b0, 2, 8'h00, 8'h20, 8'h24}); // mute
        tbl.push_back('{1'b1, 1'b0, 2, 8'h00, 8'h24, 8'h24}); // play
        tbl.push_back('{1'b1, 1'b1, 2, 8'h00, 8'h20, 8'h20}); // clear wins
        tbl.push_back('{1'b0, 1'b1, 6, 8'h00, 8'h20, 8'h20}); // clear empty bank
        tbl.push_back('{1'b0, 1'b1, 5, 8'h00, 8'h00, 8'h00}); // last bank cleared

        // Reset values
        repeat (3) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_recording", recording, 0);
        check("rst_playing", playing, 0);
        check("rst_active", active, 0);
        check("rst_loop_len", loop_len, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        step();

        foreach (tbl[i]) begin
            act_on(tbl[i].bank, tbl[i].prs, tbl[i].clr);
            check($sformatf("tbl%0d_rec", i), recording, tbl[i].rec);
            check($sformatf("tbl%0d_play", i), playing, tbl[i].play);
            check($sformatf("tbl%0d_act", i), active, tbl[i].act);
        end
        check("tbl_loop_len", loop_len, 0);

        // First recording on bank 0, 100 frames, then close it.
        ack_dly = 0;
        act_on(0, 1'b1, 1'b0);
        check("s1_rec0", recording, 8'h01);
        wr_mask = 8'h01;
        for (int k = 0; k < 100; k++) begin
            run_frame(1'b0, n);
            if (k == 0) check("s1_frame_len_min", n, 10);
        end
        act_on(0, 1'b1, 1'b0);
        check("s1_loop_len", loop_len, 100);
        check("s1_play", playing, 8'h01);
        check("s1_rec_off", recording, 8'h00);
        exp_len = 100;
        exp_pos = 0;
        wr_mask = 8'h00;
        rd_mask = 8'h01;
        // Reads 0..99, then 0..39 after the wrap.
        for (int k = 0; k < 140; k++) run_frame(1'b0, n);

        // Overlay recording on bank 3 starting at pos 40.
        act_on(3, 1'b1, 1'b0);
        check("s2_rec3", recording, 8'h08);
        wr_mask = 8'h08;
        for (int k = 0; k < 60; k++) run_frame(1'b0, n);
        wr_mask = 8'h00;
        rd_mask = 8'h09;
        check("s2_auto_rec", recording, 8'h00);
        check("s2_auto_play", playing, 8'h09);

        // Bank 5 records with slow acks; bank-order accesses and frame length.
        act_on(5, 1'b1, 1'b0);
        check("s3_rec5", recording, 8'h20);
        wr_mask = 8'h20;
        ack_dly = 2;
        run_frame(1'b0, n);
        check("s3_frame_len", n, 18);
        step();
        check("s3_done_pulse", frame_done, 0);

        // Overrun: a tick during REQ is dropped and pos is not advanced by it.
        ack_dly = 6;
        run_frame(1'b1, n);
        check("s4_overrun", overrun, 1);
        ack_dly = 0;
        run_frame(1'b0, n);
        check("s4_overrun_sticky", overrun, 1);

        act_on(5, 1'b0, 1'b1);
        wr_mask = 8'h00;
        check("s5_clr5_act", active, 8'h09);
        act_on(2, 1'b1, 1'b1);
        check("s5_clr_beats_press", active, 8'h09);
        act_on(0, 1'b0, 1'b1);
        check("s5_clr0_act", active, 8'h08);
        check("s5_clr0_len", loop_len, 100);
        act_on(3, 1'b0, 1'b1);
        check("s5_clr_all_act", active, 8'h00);
        check("s5_clr_all_len", loop_len, 0);
        rd_mask = 8'h00;
        exp_len = 0;
        exp_pos = 0;
        run_frame(1'b0, n);
        check("s5_empty_frame_len", n, 9);
        act_on(1, 1'b1, 1'b0);
        check("s5_rec1", recording, 8'h02);
        wr_mask = 8'h02;
        run_frame(1'b0, n);   // write at offset 0 confirms pos was reset

`ifdef LOOP_OVERDUB_EN
        run_frame(1'b0, n);
        run_frame(1'b0, n);
        act_on(1, 1'b1, 1'b0);
        check("od_loop_len", loop_len, 3);
        exp_len = 3;
        exp_pos = 0;
        wr_mask = 8'h00;
        rd_mask = 8'h02;
        run_frame(1'b0, n);
        act_on(1, 1'b1, 1'b0);
        check("od_rec", recording, 8'h02);
        check("od_play", playing, 8'h02);
        wr_mask = 8'h02;
        run_frame(1'b0, n);
        check("od_frame_len", n, 11);
        act_on(1, 1'b1, 1'b0);
        check("od_mute_play", playing, 8'h00);
        check("od_mute_act", active, 8'h02);
        wr_mask = 8'h00;
        rd_mask = 8'h00;
        run_frame(1'b0, n);
        check("od_mute_frame_len", n, 9);
        act_on(1, 1'b1, 1'b0);
`endif

        // Reset in the middle of an access drops mem_req at once.
        ack_dly = 100;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        check("rst_mid_req_seen", mem_req, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_req_drop", mem_req, 0);
        check("rst_mid_active", active, 0);
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_mid_overrun", overrun, 0);
        check("rst_mid_len", loop_len, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
